multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL provide parameter HALT_ON_ILLEGAL, default 1: 1 = undefined opcode enters HALT; 0 = undefined opcode returns to FETCH as a NOP.
REQ-002 SHALL have ports: Clk in 1, rising-edge clock; Reset in 1, synchronous, active-high.
REQ-003 SHALL have ports: Opcode in 6, instruction-register bits [31:26]; Zero in 1, ALU zero flag.
REQ-004 SHALL have ports: PCEn out 1, IorD out 1, MemRead out 1, MemWrite out 1, IRWrite out 1, MemtoReg out 1, RegDst out 1, RegWrite out 1, ALUSrcA out 1.
REQ-005 SHALL have ports: ALUSrcB out 2 (0=B, 1=+4, 2=SignExt, 3=SignExt<<2); ALUOp out 2 (0=add, 1=sub, 2=funct); PCSource out 2 (0=ALU, 1=ALUOut, 2=jump target).
REQ-006 SHALL have ports: State out 4, current state code; Halt out 1, high in HALT.

Function
REQ-007 SHALL be a Moore FSM: one 4-bit state register; every output except PCEn decoded from State alone; all outputs 0 unless listed for a state.
REQ-008 State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, HALT=15.
REQ-009 FETCH: MemRead, IRWrite, ALUSrcB=1, PCEn=1, PCSource=0; next DECODE.
REQ-010 DECODE: ALUSrcB=3 (branch target into ALU output register); next by Opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> IEXEC (macro only), other -> HALT or FETCH per HALT_ON_ILLEGAL.
REQ-011 MEMADR: ALUSrcA=1, ALUSrcB=2; next MEMRD if Opcode=100011, else MEMWR.
REQ-012 MEMRD: MemRead, IorD; next MEMWB. MEMWB: RegWrite, MemtoReg; next FETCH.
REQ-013 MEMWR: MemWrite, IorD; next FETCH.
REQ-014 EXEC: ALUSrcA=1, ALUOp=2; next RWB. RWB: RegWrite, RegDst; next FETCH.
REQ-015 BRANCH: ALUSrcA=1, ALUOp=1, PCSource=1, PCEn=Zero (combinational); next FETCH.
REQ-016 JUMP: PCSource=2, PCEn=1; next FETCH.
REQ-017 HALT: Halt=1, all other outputs 0, PCEn=0; remains until Reset.
REQ-018 Latency, FETCH to FETCH: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3 cycles.
REQ-019 Opcode SHALL be sampled only in DECODE and MEMADR; Zero only in BRANCH.
REQ-020 An unused state code (12-14) SHALL transition to FETCH next cycle with all outputs 0.

Reset
REQ-021 Reset high at a rising Clk edge SHALL force State=FETCH, overriding any transition, including mid-instruction and in HALT.
REQ-022 While Reset is high, outputs SHALL follow FETCH decode; the next instruction starts on the first edge after Reset falls.

Configuration
REQ-023 With MULTICYCLE_CTRL_ADDI_EN defined: IEXEC drives ALUSrcA=1, ALUSrcB=2, ALUOp=0, next IWB; IWB drives RegWrite (RegDst=0, MemtoReg=0), next FETCH.
REQ-024 Without MULTICYCLE_CTRL_ADDI_EN: IEXEC/IWB are absent, and opcode 001000 is treated as illegal per REQ-010.

Structure
REQ-025 State codes, opcode constants and ALUSrcB/ALUOp/PCSource encodings SHALL reside in shared package mips_ctrl_pkg.
REQ-026 Single module: next-state logic and output decode in separate always blocks; no sub-module.

Verification
REQ-027 Reset high 2 cycles, then Opcode=100011 -> State 0,1,2,3,4,0; RegWrite=1 only in state 4.
REQ-028 Opcode=000100, Zero=1 -> PCEn=1 in FETCH and BRANCH, PCSource=1 in BRANCH; with Zero=0, PCEn=0 in BRANCH.
REQ-029 Opcode=111111, HALT_ON_ILLEGAL=1 -> State=15, Halt=1 for 10+ cycles; Reset -> State=0.
REQ-030 Opcode=111111, HALT_ON_ILLEGAL=0 -> DECODE then FETCH; no write strobes asserted.
REQ-031 Reset asserted in MEMWR -> next State=0, MemWrite=0.
REQ-032 Opcode=001000 with macro -> states 0,1,10,11,0; without macro -> HALT.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared constants for the multicycle MIPS control unit: FSM state codes,
// primary opcodes, and the ALUSrcB / ALUOp / PCSource mux encodings.
// Optional feature macro used by importers: MULTICYCLE_CTRL_ADDI_EN
// (enables the ADDI path). The constants here are present in all builds.
// ----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // FSM state codes (4-bit). Codes 12-14 are unused.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_SEXT    = 2'd2;
    localparam logic [1:0] SRCB_SEXT_SH = 2'd3;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// Moore-style control FSM for a multicycle MIPS datapath (LW, SW, R-type,
// BEQ, J, and optionally ADDI).
//
// Optional feature macro: MULTICYCLE_CTRL_ADDI_EN
//   defined   -> opcode 001000 runs IEXEC, IWB
//   undefined -> opcode 001000 is illegal
//
// Parameters:
//   HALT_ON_ILLEGAL  1: undefined opcode parks in HALT until Reset
//                    0: undefined opcode returns to FETCH (NOP)
// Ports:
//   Clk        in   rising-edge clock
//   Reset      in   synchronous, active-high; forces FETCH
//   Opcode[5:0] in  instruction-register bits [31:26]
//   Zero       in   ALU zero flag (used only in BRANCH)
//   PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
//   ALUSrcA    out  datapath control strobes/selects
//   ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]  out  mux encodings
//   State[3:0] out  current state code
//   Halt       out  high while in HALT
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic       Halt
);

    // Plain 4-bit vector so the unused codes 12-14 are representable and
    // recover through the default arm of the next-state logic.
    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_illegal_next;

    assign w_illegal_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

    // State register: Reset wins over every transition, including HALT.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. Opcode is looked at only in DECODE and MEMADR.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
                    OP_ADDI:      w_next = S_IEXEC;
`endif
                    default:      w_next = w_illegal_next;
                endcase
            end
            S_MEMADR: w_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = S_FETCH;
            S_EXEC:   w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
`ifdef MULTICYCLE_CTRL_ADDI_EN
            S_IEXEC:  w_next = S_IWB;
            S_IWB:    w_next = S_FETCH;
`endif
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Output decode from State only; PCEn in BRANCH is the one exception
    // and follows Zero combinationally so the branch resolves this cycle.
    always_comb begin
        PCEn     = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_B;
        ALUOp    = ALUOP_ADD;
        PCSource = PCSRC_ALU;
        Halt     = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead  = 1'b1;
                IRWrite  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                PCEn     = 1'b1;
                PCSource = PCSRC_ALU;
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode decodes
                ALUSrcB = SRCB_SEXT_SH;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_SEXT;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_SUB;
                PCSource = PCSRC_ALUOUT;
                PCEn     = Zero;
            end
            S_JUMP: begin
                PCSource = PCSRC_JUMP;
                PCEn     = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_ADDI_EN
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_SEXT;
                ALUOp   = ALUOP_ADD;
            end
            S_IWB: begin
                RegWrite = 1'b1;
            end
`endif
            S_HALT: begin
                Halt = 1'b1;
            end
            default: ;
        endcase
    end

    assign State = r_state;

endmodule
